// File: rtl/unified_buffer_read_sequencer.sv
// Read-address sequencer for the unified buffer: walks an H x W activation matrix
// tile by tile (row fastest, then tile row, tile column, pass), one read per unstalled cycle.
module unified_buffer_read_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int DIM_W     = 9,
  parameter int TILE_LOG2 = 5,
  parameter int REPEAT_W  = 4,
  parameter int TRIM      = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       weights_rdy_i,
  input  logic                       stall_i,
  input  logic [DIM_W-1:0]           h_dim_i,
  input  logic [DIM_W-1:0]           w_dim_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [REPEAT_W-1:0]        repeat_i,
  output logic                       read_en_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic [DIM_W-TILE_LOG2:0]   tile_x_o,
  output logic [DIM_W-TILE_LOG2:0]   tile_y_o,
  output logic                       tile_last_o,
  output logic                       seq_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int TW = DIM_W - TILE_LOG2 + 1;
  localparam int RW = TILE_LOG2 + 1;
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(1) << TILE_LOG2;
  localparam logic [RW-1:0]     TILE_ROWS = RW'(1) << TILE_LOG2;
  localparam logic [DIM_W:0]    ROUND_UP  = (DIM_W+1)'((1 << TILE_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         nx_q, nx_d, ny_q, ny_d;
  logic [RW-1:0]         lastRows_q, lastRows_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [REPEAT_W-1:0]   rep_q, rep_d, pass_q, pass_d;
  logic [TW-1:0]         x_q, x_d, y_q, y_d;
  logic [TILE_LOG2-1:0]  r_q, r_d;
  logic [ADDR_W-1:0]     tileAddr_q, tileAddr_d;
  logic                  readEn_q, readEn_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [TW-1:0]         tileX_q, tileX_d, tileY_q, tileY_d;
  logic                  tileLast_q, tileLast_d, seqLast_q, seqLast_d;

  logic [TW-1:0]         nxIn, nyIn;
  logic [RW-1:0]         lastRowsIn, rowsInTile;
  logic                  lastR, lastY, lastX, lastPass, seqEnd;

  // Tile counts and the height of the bottom tile row, derived from the incoming dims.
  always_comb begin
    nyIn       = TW'(({1'b0, h_dim_i} + ROUND_UP) >> TILE_LOG2);
    nxIn       = TW'(({1'b0, w_dim_i} + ROUND_UP) >> TILE_LOG2);
    lastRowsIn = (h_dim_i[TILE_LOG2-1:0] == '0) ? TILE_ROWS
                                                : {1'b0, h_dim_i[TILE_LOG2-1:0]};
  end

  always_comb begin
    lastY      = (y_q == ny_q - TW'(1));
    lastX      = (x_q == nx_q - TW'(1));
    lastPass   = (pass_q == rep_q);
    rowsInTile = ((TRIM != 0) && lastY) ? lastRows_q : TILE_ROWS;
    lastR      = (({1'b0, r_q} + RW'(1)) == rowsInTile);
    seqEnd     = lastR && lastY && lastX && lastPass;
  end

  always_comb begin
    state_d    = state_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    lastRows_d = lastRows_q;
    base_d     = base_q;
    rep_d      = rep_q;
    pass_d     = pass_q;
    x_d        = x_q;
    y_d        = y_q;
    r_d        = r_q;
    tileAddr_d = tileAddr_q;
    readEn_d   = 1'b0;
    addr_d     = addr_q;
    tileX_d    = tileX_q;
    tileY_d    = tileY_q;
    tileLast_d = 1'b0;
    seqLast_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && weights_rdy_i) begin
          nx_d       = nxIn;
          ny_d       = nyIn;
          lastRows_d = lastRowsIn;
          base_d     = base_addr_i;
          rep_d      = repeat_i;
          pass_d     = '0;
          x_d        = '0;
          y_d        = '0;
          r_d        = '0;
          tileAddr_d = base_addr_i;
          state_d    = ((h_dim_i == '0) || (w_dim_i == '0)) ? DONE : READ;
        end
      end
      READ: begin
        // The final read is on the outputs this cycle, so done follows directly behind it.
        if (readEn_q && seqLast_q) begin
          state_d = DONE;
        end else if (!stall_i) begin
          readEn_d   = 1'b1;
          addr_d     = tileAddr_q + ADDR_W'(r_q);
          tileX_d    = x_q;
          tileY_d    = y_q;
          tileLast_d = lastR;
          seqLast_d  = seqEnd;
          if (!lastR) begin
            r_d = r_q + TILE_LOG2'(1);
          end else begin
            r_d        = '0;
            tileAddr_d = tileAddr_q + TILE_STEP;
            if (!lastY) begin
              y_d = y_q + TW'(1);
            end else begin
              y_d = '0;
              if (!lastX) begin
                x_d = x_q + TW'(1);
              end else begin
                x_d        = '0;
                pass_d     = pass_q + REPEAT_W'(1);
                tileAddr_d = base_q;
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      nx_q       <= '0;
      ny_q       <= '0;
      lastRows_q <= '0;
      base_q     <= '0;
      rep_q      <= '0;
      pass_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      tileAddr_q <= '0;
      readEn_q   <= 1'b0;
      addr_q     <= '0;
      tileX_q    <= '0;
      tileY_q    <= '0;
      tileLast_q <= 1'b0;
      seqLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      lastRows_q <= lastRows_d;
      base_q     <= base_d;
      rep_q      <= rep_d;
      pass_q     <= pass_d;
      x_q        <= x_d;
      y_q        <= y_d;
      r_q        <= r_d;
      tileAddr_q <= tileAddr_d;
      readEn_q   <= readEn_d;
      addr_q     <= addr_d;
      tileX_q    <= tileX_d;
      tileY_q    <= tileY_d;
      tileLast_q <= tileLast_d;
      seqLast_q  <= seqLast_d;
    end
  end

  assign read_en_o   = readEn_q;
  assign addr_o      = addr_q;
  assign tile_x_o    = tileX_q;
  assign tile_y_o    = tileY_q;
  assign tile_last_o = tileLast_q;
  assign seq_last_o  = seqLast_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_unified_buffer_read_sequencer.sv
// Scoreboard bench: a trimmed and an untrimmed sequencer share stimulus; a reference
// model queues every expected read and each observed read is popped and compared.
module tb_unified_buffer_read_sequencer;

  logic        clk, rst, start, weightsRdy, stall;
  logic [8:0]  hDim, wDim;
  logic [11:0] baseAddr;
  logic [3:0]  rep;

  logic        readEn1, tileLast1, seqLast1, busy1, done1;
  logic [11:0] addr1;
  logic [4:0]  tileX1, tileY1;
  logic        readEn0, tileLast0, seqLast0, busy0, done0;
  logic [11:0] addr0;
  logic [4:0]  tileX0, tileY0;

  logic [31:0] expQ1[$];
  logic [31:0] expQ0[$];
  int          checks   = 0;
  int          failures = 0;

  unified_buffer_read_sequencer #(.TRIM(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .weights_rdy_i(weightsRdy), .stall_i(stall),
    .h_dim_i(hDim), .w_dim_i(wDim), .base_addr_i(baseAddr), .repeat_i(rep),
    .read_en_o(readEn1), .addr_o(addr1), .tile_x_o(tileX1), .tile_y_o(tileY1),
    .tile_last_o(tileLast1), .seq_last_o(seqLast1), .busy_o(busy1), .done_o(done1)
  );

  unified_buffer_read_sequencer #(.TRIM(0)) dutNoTrim (
    .clk_i(clk), .rst_i(rst), .start_i(start), .weights_rdy_i(weightsRdy), .stall_i(stall),
    .h_dim_i(hDim), .w_dim_i(wDim), .base_addr_i(baseAddr), .repeat_i(rep),
    .read_en_o(readEn0), .addr_o(addr0), .tile_x_o(tileX0), .tile_y_o(tileY0),
    .tile_last_o(tileLast0), .seq_last_o(seqLast0), .busy_o(busy0), .done_o(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference walk using the closed-form address; returns the number of reads queued.
  task automatic pushModel(input int h, input int w, input int base, input int rp,
                           input int trim, output int n);
    int ny, nx, rows, a;
    logic [31:0] e;
    n = 0;
    if (h == 0 || w == 0) return;
    ny = (h + 31) / 32;
    nx = (w + 31) / 32;
    for (int p = 0; p <= rp; p++)
      for (int x = 0; x < nx; x++)
        for (int y = 0; y < ny; y++) begin
          rows = (trim != 0 && y == ny - 1) ? h - (ny - 1) * 32 : 32;
          for (int r = 0; r < rows; r++) begin
            a = (base + (x * ny + y) * 32 + r) % 4096;
            e = {8'h00, 12'(a), 5'(x), 5'(y), 1'(r == rows - 1),
                 1'((r == rows - 1) && (y == ny - 1) && (x == nx - 1) && (p == rp))};
            if (trim != 0) expQ1.push_back(e);
            else           expQ0.push_back(e);
            n++;
          end
        end
  endtask

  task automatic applyStimulus(input int h, input int w, input int base, input int rp,
                               input int stallAt, input int stallLen, input int pulseAt,
                               input int resetAt);
    int n1, n0, readCnt1, readCnt0, doneAt1, doneAt0, stallLeft;
    bit pulsed;
    logic [31:0] obs;
    expQ1.delete();
    expQ0.delete();
    pushModel(h, w, base, rp, 1, n1);
    pushModel(h, w, base, rp, 0, n0);
    readCnt1 = 0; readCnt0 = 0; doneAt1 = -1; doneAt0 = -1;
    stallLeft = stallLen; pulsed = 1'b0;
    hDim = 9'(h); wDim = 9'(w); baseAddr = 12'(base); rep = 4'(rp);
    weightsRdy = 1'b1; stall = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rstReadEn", {31'b0, readEn1}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy1}, 32'd0);
        checkOutput("rstBusyNoTrim", {31'b0, busy0}, 32'd0);
        rst = 1'b0;
        break;
      end
      if (readEn1) begin
        readCnt1++;
        obs = {8'h00, addr1, tileX1, tileY1, tileLast1, seqLast1};
        if (expQ1.size() == 0) checkOutput("extraRead", readCnt1, n1);
        else checkOutput("read", obs, expQ1.pop_front());
      end
      if (readEn0) begin
        readCnt0++;
        obs = {8'h00, addr0, tileX0, tileY0, tileLast0, seqLast0};
        if (expQ0.size() == 0) checkOutput("extraReadNoTrim", readCnt0, n0);
        else checkOutput("readNoTrim", obs, expQ0.pop_front());
      end
      if (done1 && doneAt1 < 0) doneAt1 = cyc;
      if (done0 && doneAt0 < 0) doneAt0 = cyc;
      start = 1'b0;
      stall = 1'b0;
      hDim = 9'($urandom); wDim = 9'($urandom); baseAddr = 12'($urandom); rep = 4'($urandom);
      if (doneAt1 >= 0 && doneAt0 >= 0) break;
      if (stallAt >= 0 && readCnt1 == stallAt && stallLeft > 0) begin
        stall = 1'b1;
        stallLeft--;
      end
      if (pulseAt >= 0 && readCnt1 == pulseAt && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (resetAt >= 0 && readCnt1 == resetAt) rst = 1'b1;
    end
    start = 1'b0;
    stall = 1'b0;
    if (resetAt < 0) begin
      checkOutput("readCount", readCnt1, n1);
      checkOutput("readCountNoTrim", readCnt0, n0);
      checkOutput("doneCycle", doneAt1, (n1 == 0) ? 0 : n1 + 1 + stallLen);
      checkOutput("doneCycleNoTrim", doneAt0, (n0 == 0) ? 0 : n0 + 1 + stallLen);
    end
    @(negedge clk);
    checkOutput("idleBusy", {31'b0, busy1}, 32'd0);
    checkOutput("idleDone", {31'b0, done1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; weightsRdy = 1'b0; stall = 1'b0;
    hDim = '0; wDim = '0; baseAddr = '0; rep = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetReadEn", {31'b0, readEn1}, 32'd0);
    checkOutput("resetBusy", {31'b0, busy1}, 32'd0);
    checkOutput("resetDone", {31'b0, done1}, 32'd0);
    checkOutput("resetAddr", {20'b0, addr1}, 32'd0);
    checkOutput("resetSeqLast", {31'b0, seqLast1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    hDim = 9'd32; wDim = 9'd32; start = 1'b1; weightsRdy = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("noWeightsBusy", {31'b0, busy1}, 32'd0);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] basic two tile rows");
    applyStimulus(64, 32, 'h100, 0, -1, 0, -1, -1);
    $display("[TB] partial tiles");
    applyStimulus(40, 70, 0, 0, -1, 0, -1, -1);
    $display("[TB] stall for three cycles");
    applyStimulus(32, 32, 'h080, 0, 10, 3, -1, -1);
    $display("[TB] address wrap");
    applyStimulus(32, 32, 'hFF0, 0, -1, 0, -1, -1);
    $display("[TB] repeat passes with stray start");
    applyStimulus(32, 64, 'h300, 2, -1, 0, 50, -1);
    $display("[TB] zero height");
    applyStimulus(0, 5, 'h010, 0, -1, 0, -1, -1);
    $display("[TB] reset mid sequence then restart");
    applyStimulus(64, 64, 'h200, 0, -1, 0, -1, 20);
    applyStimulus(64, 32, 'h200, 0, -1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
